// File: rtl/vga_sync_gen.sv
// Vertical timing stage behind the horizontal pixel counter: line counter, shadowed mode
// registers and registered HSync/VSync, active-video flag, pixel coordinates and frame start.
module vga_sync_gen #(
  parameter int REZ_WIDTH     = 11,
  parameter int REZ_MAX_WIDTH = 12,
  parameter int DEF_H_ACTIVE  = 640,
  parameter int DEF_H_FRONT   = 16,
  parameter int DEF_H_SYNC    = 96,
  parameter int DEF_V_ACTIVE  = 480,
  parameter int DEF_V_FRONT   = 10,
  parameter int DEF_V_SYNC    = 2,
  parameter int DEF_V_TOTAL   = 525
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic [REZ_MAX_WIDTH-1:0] CounterP,
  input  logic                     Counter_sync,
  input  logic [REZ_WIDTH-1:0]     H_active,
  input  logic [REZ_MAX_WIDTH-1:0] H_front,
  input  logic [REZ_MAX_WIDTH-1:0] H_sync,
  input  logic [REZ_WIDTH-1:0]     V_active,
  input  logic [REZ_MAX_WIDTH-1:0] V_front,
  input  logic [REZ_MAX_WIDTH-1:0] V_sync,
  input  logic [REZ_MAX_WIDTH-1:0] V_total,
  input  logic                     H_pol,
  input  logic                     V_pol,
  output logic                     HSync,
  output logic                     VSync,
  output logic                     Video_on,
  output logic [REZ_WIDTH-1:0]     Pixel_x,
  output logic [REZ_WIDTH-1:0]     Pixel_y,
  output logic                     Frame_start
);

  localparam int PAD = REZ_MAX_WIDTH - REZ_WIDTH;

  logic [REZ_MAX_WIDTH-1:0] v_count_q, v_count_d;
  logic [REZ_WIDTH-1:0]     h_active_q, v_active_q;
  logic [REZ_MAX_WIDTH-1:0] h_front_q, h_sync_q, v_front_q, v_sync_q, v_total_q;
  logic                     h_pol_q, v_pol_q;

  logic                     hsync_q, hsync_d;
  logic                     vsync_q, vsync_d;
  logic                     video_q, video_d;
  logic [REZ_WIDTH-1:0]     pixel_x_q, pixel_x_d;
  logic [REZ_WIDTH-1:0]     pixel_y_q, pixel_y_d;
  logic                     frame_start_q, frame_start_d;

  logic [REZ_MAX_WIDTH-1:0] hs_start, hs_end, vs_start, vs_end;
  logic                     hs_pos, vs_pos, h_vis, v_vis, last_line;

  always_comb begin
    hs_start  = {{PAD{1'b0}}, h_active_q} + h_front_q;
    hs_end    = hs_start + h_sync_q;
    vs_start  = {{PAD{1'b0}}, v_active_q} + v_front_q;
    vs_end    = vs_start + v_sync_q;
    // Half-open windows: a zero-width sync can never satisfy both bounds.
    hs_pos    = (CounterP >= hs_start) && (CounterP < hs_end);
    vs_pos    = (v_count_q >= vs_start) && (v_count_q < vs_end);
    h_vis     = CounterP < {{PAD{1'b0}}, h_active_q};
    v_vis     = v_count_q < {{PAD{1'b0}}, v_active_q};
    last_line = v_count_q == (v_total_q - 1'b1);

    hsync_d       = hs_pos ? h_pol_q : ~h_pol_q;
    vsync_d       = vs_pos ? v_pol_q : ~v_pol_q;
    video_d       = h_vis && v_vis;
    pixel_x_d     = video_d ? CounterP[REZ_WIDTH-1:0] : '0;
    pixel_y_d     = video_d ? v_count_q[REZ_WIDTH-1:0] : '0;
    frame_start_d = (CounterP == '0) && (v_count_q == '0);

    v_count_d = v_count_q;
    if (Counter_sync) begin
      v_count_d = last_line ? '0 : v_count_q + 1'b1;
    end
  end

  // Mode registers only follow the inputs at the frame wrap so a frame is never torn.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      h_active_q <= REZ_WIDTH'(DEF_H_ACTIVE);
      h_front_q  <= REZ_MAX_WIDTH'(DEF_H_FRONT);
      h_sync_q   <= REZ_MAX_WIDTH'(DEF_H_SYNC);
      v_active_q <= REZ_WIDTH'(DEF_V_ACTIVE);
      v_front_q  <= REZ_MAX_WIDTH'(DEF_V_FRONT);
      v_sync_q   <= REZ_MAX_WIDTH'(DEF_V_SYNC);
      v_total_q  <= REZ_MAX_WIDTH'(DEF_V_TOTAL);
      h_pol_q    <= 1'b0;
      v_pol_q    <= 1'b0;
    end else if (Counter_sync && last_line) begin
      h_active_q <= H_active;
      h_front_q  <= H_front;
      h_sync_q   <= H_sync;
      v_active_q <= V_active;
      v_front_q  <= V_front;
      v_sync_q   <= V_sync;
      v_total_q  <= V_total;
      h_pol_q    <= H_pol;
      v_pol_q    <= V_pol;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      v_count_q     <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      video_q       <= 1'b0;
      pixel_x_q     <= '0;
      pixel_y_q     <= '0;
      frame_start_q <= 1'b0;
    end else begin
      v_count_q     <= v_count_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_q       <= video_d;
      pixel_x_q     <= pixel_x_d;
      pixel_y_q     <= pixel_y_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign HSync       = hsync_q;
  assign VSync       = vsync_q;
  assign Video_on    = video_q;
  assign Pixel_x     = pixel_x_q;
  assign Pixel_y     = pixel_y_q;
  assign Frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Randomized bench for vga_sync_gen: drives a horizontal counter stream and compares every
// registered output against a frame-level reference model of line numbering and mode loading.
module tb_vga_sync_gen;

  typedef struct {
    int ha; int hf; int hs; int ht;
    int va; int vf; int vs; int vt;
    bit hp; bit vp;
  } cfg_t;

  typedef struct {
    bit hs; bit vs; bit von; int px; int py; bit fs;
  } exp_t;

  logic        Clk;
  logic        Rst;
  logic [11:0] CounterP;
  logic        Counter_sync;
  logic [10:0] H_active, V_active;
  logic [11:0] H_front, H_sync, V_front, V_sync, V_total;
  logic        H_pol, V_pol;
  logic        HSync, VSync, Video_on, Frame_start;
  logic [10:0] Pixel_x, Pixel_y;

  cfg_t cfg_in, m_cfg, def_cfg, chg_cfg;
  int   m_line;
  int   chg_line;
  int   rst_line, rst_pix;
  int   n_checks, n_fail;

  vga_sync_gen dut (
    .Clk(Clk), .Rst(Rst), .CounterP(CounterP), .Counter_sync(Counter_sync),
    .H_active(H_active), .H_front(H_front), .H_sync(H_sync),
    .V_active(V_active), .V_front(V_front), .V_sync(V_sync), .V_total(V_total),
    .H_pol(H_pol), .V_pol(V_pol),
    .HSync(HSync), .VSync(VSync), .Video_on(Video_on),
    .Pixel_x(Pixel_x), .Pixel_y(Pixel_y), .Frame_start(Frame_start)
  );

  assign H_active = 11'(cfg_in.ha);
  assign H_front  = 12'(cfg_in.hf);
  assign H_sync   = 12'(cfg_in.hs);
  assign V_active = 11'(cfg_in.va);
  assign V_front  = 12'(cfg_in.vf);
  assign V_sync   = 12'(cfg_in.vs);
  assign V_total  = 12'(cfg_in.vt);
  assign H_pol    = cfg_in.hp;
  assign V_pol    = cfg_in.vp;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (model line %0d, t=%0t)", tag, got, exp, m_line, $time);
    end
  endtask

  // Reference: outputs are a pure function of position, line and the frame's mode.
  function automatic exp_t model_out(input int hpos, input int line, input cfg_t c);
    exp_t e;
    bit   in_hs, in_vs;
    in_hs = (hpos >= c.ha + c.hf) && (hpos < c.ha + c.hf + c.hs);
    in_vs = (line >= c.va + c.vf) && (line < c.va + c.vf + c.vs);
    e.hs  = in_hs ? c.hp : !c.hp;
    e.vs  = in_vs ? c.vp : !c.vp;
    e.von = (hpos < c.ha) && (line < c.va);
    e.px  = e.von ? hpos : 0;
    e.py  = e.von ? line : 0;
    e.fs  = (hpos == 0) && (line == 0);
    return e;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_hsync"}, 32'(HSync), 32'd1);
    check_val({tag, "_vsync"}, 32'(VSync), 32'd1);
    check_val({tag, "_video"}, 32'(Video_on), 32'd0);
    check_val({tag, "_px"}, 32'(Pixel_x), 32'd0);
    check_val({tag, "_py"}, 32'(Pixel_y), 32'd0);
    check_val({tag, "_fs"}, 32'(Frame_start), 32'd0);
  endtask

  // Asserted mid-cycle so the checks prove the outputs clear without a clock edge.
  task automatic do_reset();
    #2;
    Rst = 1'b0;
    #1;
    check_reset_outputs("rst_async");
    m_line = 0;
    m_cfg  = def_cfg;
    CounterP = '0;
    Counter_sync = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    check_reset_outputs("rst_held");
    Rst = 1'b1;
  endtask

  task automatic cycle(input int hpos, input bit sync);
    exp_t e;
    CounterP = 12'(hpos);
    Counter_sync = sync;
    e = model_out(hpos, m_line, m_cfg);
    @(posedge Clk);
    #1;
    check_val("hsync", 32'(HSync), 32'(e.hs));
    check_val("vsync", 32'(VSync), 32'(e.vs));
    check_val("video_on", 32'(Video_on), 32'(e.von));
    check_val("pixel_x", 32'(Pixel_x), 32'(e.px));
    check_val("pixel_y", 32'(Pixel_y), 32'(e.py));
    check_val("frame_start", 32'(Frame_start), 32'(e.fs));
    if (sync) begin
      if (m_line == m_cfg.vt - 1) begin
        m_line = 0;
        m_cfg  = cfg_in;
      end else begin
        m_line++;
      end
    end
  endtask

  // Lines away from the interesting rows use a sparse position sweep to keep runtime low.
  task automatic drive_line(output bit aborted);
    int  ln, ht;
    bit  full;
    int  pos[$];
    ln = m_line;
    ht = m_cfg.ht;
    aborted = 1'b0;
    if (ln == chg_line) begin
      cfg_in = chg_cfg;
      chg_line = -1;
    end
    full = (ht <= 64) || (ln < 2) || (ln == rst_line) ||
           (ln == m_cfg.va - 1) || (ln == m_cfg.va) || (ln == m_cfg.va + m_cfg.vf) ||
           (ln == m_cfg.va + m_cfg.vf + m_cfg.vs - 1) || (ln == m_cfg.va + m_cfg.vf + m_cfg.vs) ||
           (ln == m_cfg.vt - 1) || ($urandom_range(0, 127) == 0);
    pos.delete();
    if (full) begin
      for (int p = 0; p < ht; p++) pos.push_back(p);
    end else begin
      for (int p = 0; p < 4; p++) pos.push_back(p);
      for (int k = 0; k < 4; k++) pos.push_back(int'($urandom_range(4, ht - 2)));
      pos.push_back(ht - 1);
    end
    foreach (pos[i]) begin
      cycle(pos[i], i == pos.size() - 1);
      if (ln == rst_line && pos[i] == rst_pix) begin
        rst_line = -1;
        do_reset();
        aborted = 1'b1;
        return;
      end
    end
  endtask

  task automatic run_frame();
    bit aborted;
    do begin
      drive_line(aborted);
    end while (m_line != 0 && !aborted);
  endtask

  function automatic cfg_t rand_cfg();
    cfg_t c;
    c.ha = $urandom_range(0, 40);
    c.hf = $urandom_range(0, 8);
    c.hs = $urandom_range(0, 8);
    c.ht = c.ha + c.hf + c.hs + int'($urandom_range(6, 10));
    c.va = $urandom_range(0, 10);
    c.vf = $urandom_range(0, 3);
    c.vs = $urandom_range(0, 3);
    c.vt = c.va + c.vf + c.vs + int'($urandom_range(1, 3));
    c.hp = 1'($urandom_range(0, 1));
    c.vp = 1'($urandom_range(0, 1));
    return c;
  endfunction

  initial begin
    bit aborted;
    n_checks = 0;
    n_fail   = 0;
    def_cfg  = '{ha:640, hf:16, hs:96, ht:800, va:480, vf:10, vs:2, vt:525, hp:1'b0, vp:1'b0};
    cfg_in   = def_cfg;
    m_cfg    = def_cfg;
    m_line   = 0;
    chg_line = -1;
    rst_line = -1;
    rst_pix  = -1;
    Rst      = 1'b1;
    CounterP = '0;
    Counter_sync = 1'b0;
    #4;
    do_reset();

    // Default frame; at line 100 request 1024-wide mode with positive sync polarity.
    chg_cfg  = '{ha:1024, hf:48, hs:32, ht:1184, va:6, vf:1, vs:2, vt:12, hp:1'b1, vp:1'b1};
    chg_line = 100;
    run_frame();

    // 1024-wide frame; mid-frame request a mode with no HSync and no active lines.
    chg_cfg  = '{ha:32, hf:4, hs:0, ht:48, va:0, vf:2, vs:2, vt:8, hp:1'b0, vp:1'b1};
    chg_line = 3;
    run_frame();

    // Degenerate frame, then a run of random small modes each loaded mid-frame.
    for (int f = 0; f < 5; f++) begin
      chg_cfg  = rand_cfg();
      chg_line = $urandom_range(0, m_cfg.vt - 1);
      run_frame();
    end

    // Reset inside a random-mode frame, then reset again at line 300, pixel 200 of default.
    chg_line = -1;
    cfg_in   = def_cfg;
    rst_line = m_cfg.vt - 1;
    rst_pix  = 2;
    run_frame();
    rst_line = 300;
    rst_pix  = 200;
    run_frame();
    for (int l = 0; l < 5; l++) drive_line(aborted);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached at t=%0t", $time);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
